// File: rtl/tube_display_ctrl.sv
// tube_display_ctrl
//   Eight-digit seven-segment scan controller. It multiplexes the board tube
//   pins between a CPU-written display value and a debug view of the PC. The
//   debug view is selected while `finish` is held. All visible state is taken
//   from shadow registers that are reloaded only at frame boundaries, so a
//   frame never mixes two values or two sources.
//
//   Build option: define TUBE_LEADING_ZERO_BLANK_EN to darken, in the CPU view,
//   every digit above the most significant non-zero nibble. Digit 0 always
//   stays lit.
//
// Ports
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   wr_en             single-cycle MMIO write strobe
//   wr_sel            0 = value register, 1 = blank-mask register
//   wr_data[31:0]     write data; the blank mask uses [7:0]
//   finish            debug-view request (asynchronous button)
//   dbg_pc[7:0]       PC low byte shown in the debug view
//   tube_scan[7:0]    one-hot digit enable; bit i = digit i, digit 0 rightmost
//   tube_signal_left  {dp,g,f,e,d,c,b,a} for digits 7..4
//   tube_signal_right {dp,g,f,e,d,c,b,a} for digits 3..0

module tube_display_ctrl #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [31:0] wr_data,
    input  logic        finish,
    input  logic [7:0]  dbg_pc,
    output logic [7:0]  tube_scan,
    output logic [7:0]  tube_signal_left,
    output logic [7:0]  tube_signal_right
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [7:0] SEG_P = 8'h73;

    // Programmer-visible registers
    logic [31:0] value_q;
    logic [7:0]  blank_q;

    // Synchronizer for the asynchronous finish button
    logic fin_meta;
    logic fin_s;

    // Scan timing
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic             digit_end;
    logic             frame_end;

    // Frame snapshot
    logic [31:0] sh_value;
    logic [7:0]  sh_blank;
    logic        sh_dbg;
    logic [7:0]  sh_pc;

    // Next-cycle output values
    logic [3:0] cur_nibble;
    logic       lz_dark;
    logic [7:0] cpu_code;
    logic [7:0] dbg_code;
    logic [7:0] seg_code;
    logic [7:0] scan_nxt;
    logic [7:0] left_nxt;
    logic [7:0] right_nxt;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'h3F;
            4'h1:    s = 8'h06;
            4'h2:    s = 8'h5B;
            4'h3:    s = 8'h4F;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'h6D;
            4'h6:    s = 8'h7D;
            4'h7:    s = 8'h07;
            4'h8:    s = 8'h7F;
            4'h9:    s = 8'h6F;
            4'hA:    s = 8'h77;
            4'hB:    s = 8'h7C;
            4'hC:    s = 8'h39;
            4'hD:    s = 8'h5E;
            4'hE:    s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            blank_q <= '0;
        end else if (wr_en) begin
            if (wr_sel) begin
                blank_q <= wr_data[7:0];
            end else begin
                value_q <= wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // finish synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fin_meta <= 1'b0;
            fin_s    <= 1'b0;
        end else begin
            fin_meta <= finish;
            fin_s    <= fin_meta;
        end
    end

    // ------------------------------------------------------------------
    // Digit / frame timing
    // ------------------------------------------------------------------
    assign digit_end = (div_cnt == DIV_LAST);
    assign frame_end = digit_end && (idx == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (digit_end) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Shadows load on the same edge that idx wraps to 0. A write on that
    // edge lands in value_q/blank_q only, so the snapshot keeps the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_value <= '0;
            sh_blank <= '0;
            sh_dbg   <= 1'b0;
            sh_pc    <= '0;
        end else if (frame_end) begin
            sh_value <= value_q;
            sh_blank <= blank_q;
            sh_dbg   <= fin_s;
            sh_pc    <= dbg_pc;
        end
    end

    // ------------------------------------------------------------------
    // Segment selection for the current digit
    // ------------------------------------------------------------------
    assign cur_nibble = sh_value[{idx, 2'b00} +: 4];

`ifdef TUBE_LEADING_ZERO_BLANK_EN
    // lz_top is the highest digit with a non-zero nibble. It stays 0 for an
    // all-zero value, so digit 0 is always lit.
    logic [2:0] lz_top;

    always_comb begin
        lz_top = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (sh_value[i*4 +: 4] != 4'h0) begin
                lz_top = 3'(i);
            end
        end
        lz_dark = (idx > lz_top);
    end
`else
    assign lz_dark = 1'b0;
`endif

    always_comb begin
        cpu_code = '0;
        if (!(sh_blank[idx] || lz_dark)) begin
            cpu_code = hex_seg(cur_nibble);
        end
    end

    always_comb begin
        dbg_code = '0;
        case (idx)
            3'd7:    dbg_code = SEG_P;
            3'd1:    dbg_code = hex_seg(sh_pc[7:4]);
            3'd0:    dbg_code = hex_seg(sh_pc[3:0]);
            default: dbg_code = '0;
        endcase
    end

    always_comb begin
        seg_code  = sh_dbg ? dbg_code : cpu_code;
        scan_nxt  = 8'h01 << idx;
        left_nxt  = '0;
        right_nxt = '0;
        if (idx[2]) begin
            left_nxt  = seg_code;
        end else begin
            right_nxt = seg_code;
        end
    end

    // ------------------------------------------------------------------
    // Output registers (one cycle behind idx)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tube_scan         <= '0;
            tube_signal_left  <= '0;
            tube_signal_right <= '0;
        end else begin
            tube_scan         <= scan_nxt;
            tube_signal_left  <= left_nxt;
            tube_signal_right <= right_nxt;
        end
    end

endmodule

// File: tb/tb_tube_display_ctrl.sv
module tb_tube_display_ctrl;

    localparam int unsigned D     = 4;
    localparam int unsigned FRAME = 8 * D;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [31:0] wr_data;
    logic        finish;
    logic [7:0]  dbg_pc;
    logic [7:0]  tube_scan;
    logic [7:0]  tube_signal_left;
    logic [7:0]  tube_signal_right;

    always #5 clk = ~clk;

    tube_display_ctrl #(.SCAN_DIV(D)) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_en             (wr_en),
        .wr_sel            (wr_sel),
        .wr_data           (wr_data),
        .finish            (finish),
        .dbg_pc            (dbg_pc),
        .tube_scan         (tube_scan),
        .tube_signal_left  (tube_signal_left),
        .tube_signal_right (tube_signal_right)
    );

    typedef struct packed {
        logic [7:0] scan;
        logic [7:0] left;
        logic [7:0] right;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Reference model state: time is a cycle count since reset release;
    // digit index and frame boundaries are derived arithmetically from it.
    int unsigned cyc = 0;
    logic [31:0] m_value = '0;
    logic [7:0]  m_blank = '0;
    logic        m_s1 = 1'b0;
    logic        m_fin = 1'b0;
    logic [31:0] s_value = '0;
    logic [7:0]  s_blank = '0;
    logic        s_dbg = 1'b0;
    logic [7:0]  s_pc = '0;

    function automatic logic [7:0] digit_code(input int unsigned d, input logic [31:0] v,
                                              input logic [7:0] b, input logic dbg,
                                              input logic [7:0] pc);
        logic [3:0] nib;
        int unsigned top;
        if (dbg) begin
            if (d == 7) return 8'h73;
            if (d == 1) return seg_tab[pc[7:4]];
            if (d == 0) return seg_tab[pc[3:0]];
            return 8'h00;
        end
        nib = v[4*d +: 4];
        top = 0;
`ifdef TUBE_LEADING_ZERO_BLANK_EN
        for (int unsigned k = 0; k < 8; k++) begin
            if (v[4*k +: 4] != 4'h0) top = k;
        end
        if (d > top) return 8'h00;
`endif
        if (b[d]) return 8'h00;
        return seg_tab[nib];
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        int unsigned d;
        logic [7:0] code;
        e = '0;
        if (rst) begin
            cyc = 0; m_value = '0; m_blank = '0; m_s1 = 1'b0; m_fin = 1'b0;
            s_value = '0; s_blank = '0; s_dbg = 1'b0; s_pc = '0;
        end else begin
            d = (cyc / D) % 8;
            code = digit_code(d, s_value, s_blank, s_dbg, s_pc);
            e.scan = 8'(1 << d);
            if (d < 4) e.right = code;
            else       e.left  = code;
            if (cyc % FRAME == FRAME - 1) begin
                s_value = m_value; s_blank = m_blank; s_dbg = m_fin; s_pc = dbg_pc;
            end
            if (wr_en) begin
                if (wr_sel) m_blank = wr_data[7:0];
                else        m_value = wr_data;
            end
            m_fin = m_s1;
            m_s1  = finish;
            cyc++;
        end
        sb_q.push_back(e);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %02h expected %02h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("tube_scan", tube_scan, e.scan);
            check("tube_signal_left", tube_signal_left, e.left);
            check("tube_signal_right", tube_signal_right, e.right);
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic sel, input logic [31:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_data = data;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_phase(input int unsigned ph);
        int unsigned budget;
        budget = 2 * FRAME;
        while ((cyc % FRAME) != ph && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) begin
            n_bad++;
            $display("FAIL wait_phase: phase %0d not reached, got %0d", ph, cyc % FRAME);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; finish = 1'b0; dbg_pc = '0;
        tick(3);
        rst = 1'b0;
        tick(FRAME);

        wait_phase(10);
        write_reg(1'b0, 32'h12345678);
        tick(2 * FRAME);

        write_reg(1'b1, 32'h000000F0);
        write_reg(1'b0, 32'hDEADBEEF);
        tick(2 * FRAME);

        write_reg(1'b1, 32'h0);
        dbg_pc = 8'h3A;
        finish = 1'b1;
        tick(2 * FRAME);
        finish = 1'b0;
        tick(2 * FRAME);

        wait_phase(FRAME - 1);
        write_reg(1'b0, 32'hCAFEF00D);
        tick(2 * FRAME);

        wait_phase(5 * D + 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(FRAME + 2);

        write_reg(1'b0, 32'h00000A05);
        wait_phase(4);
        finish = 1'b1;
        tick(10);
        finish = 1'b0;
        tick(2 * FRAME);

        write_reg(1'b0, 32'h0);
        tick(2 * FRAME);

        for (int unsigned i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_sel  = ($urandom_range(0, 3) == 0);
            wr_data = $urandom >> $urandom_range(0, 31);
            dbg_pc  = 8'($urandom);
            if ($urandom_range(0, 39) == 0) finish = ~finish;
            tick(1);
        end
        wr_en = 1'b0;
        tick(FRAME);

        if (n_cmp < 300) begin
            n_bad++;
            $display("FAIL compare_count: got %0d expected at least 300", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tube_display_ctrl.md
# tube_display_ctrl

Eight-digit seven-segment scan controller between the CPU's MMIO write port and the board tube pins. It owns the `tube_scan` / `tube_signal_left` / `tube_signal_right` resource and arbitrates it between two sources: the CPU-written display value and a debug view of the PC, which is selected while `finish` is held. It sequences the digit multiplexing and hex-to-segment decode. Source and value changes are applied only at frame boundaries so the display never tears.

## Interface
- `SCAN_DIV`, default 100000: clk cycles per digit (1 kHz digit rate at 100 MHz); legal range ≥ 2.
- `clk` input 1: system clock; all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: MMIO write strobe, single-cycle, no backpressure.
- `wr_sel` input 1: 0 = value register, 1 = blank-mask register.
- `wr_data` input 32: write data; the blank mask uses `[7:0]`.
- `finish` input 1: debug-view request (asynchronous button).
- `dbg_pc` input 8: PC low byte, shown in the debug view.
- `tube_scan` output 8: one-hot digit enable, active-high; bit i = digit i, where digit 0 is the rightmost.
- `tube_signal_left` output 8: segments `{dp,g,f,e,d,c,b,a}`, active-high, for digits 7..4.
- `tube_signal_right` output 8: segments `{dp,g,f,e,d,c,b,a}`, active-high, for digits 3..0.

## Operation
- Registers:
  - `value[31:0]`: nibble i → digit i.
  - `blank[7:0]`: bit i = 1 forces digit i dark.
  - Both are written on the cycle after `wr_en`; writes with the same cycle overwrite in order, last write wins.
- `finish` passes through a 2-flop synchronizer to give `fin_s`.
- Scan state:
  - `div_cnt` counts 0..SCAN_DIV-1.
  - When `div_cnt` = SCAN_DIV-1, `div_cnt` returns to 0 and `idx[2:0]` increments; 7 wraps to 0.
- Frame boundary: the cycle `idx` wraps 7→0. In that cycle the shadow registers are loaded: `sh_value` ← `value`, `sh_blank` ← `blank`, `sh_dbg` ← `fin_s`, `sh_pc` ← `dbg_pc`.
- Source arbitration, using shadows only:
  - `sh_dbg` = 0, CPU view: digit i shows hex of `sh_value[4i+3:4i]`, or is dark if `sh_blank[i]`.
  - `sh_dbg` = 1, debug view: digit 7 = 'P' (0x73), digits 1..0 = hex of `sh_pc`, all other digits dark. `sh_blank` is ignored.
- Hex code table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. A dark digit has segments 0x00. The dp bit is always 0.
- Output mapping:
  - `tube_scan` = 1<<idx. It is still asserted for dark digits; their segments are 0.
  - For idx 0..3, `tube_signal_right` = code and `tube_signal_left` = 0.
  - For idx 4..7, `tube_signal_left` = code and `tube_signal_right` = 0.
- All three outputs are registered from `idx` and the shadows, so they lag `idx` by 1 cycle.

## Timing
- Reset state:
  - `div_cnt` = 0, `idx` = 0, `value` = 0, `blank` = 0.
  - Shadows = 0, synchronizer = 0.
  - All outputs = 0x00.
- First cycle after reset deassertion: `tube_scan` = 0x01 and `tube_signal_right` = 0x3F.
- Digit dwell is exactly SCAN_DIV cycles; one frame = 8·SCAN_DIV cycles.
- Write → display latency: the change appears at the next frame boundary.
- Write in the same cycle as a boundary: the snapshot takes the old value, and the new value appears one frame later.
- `finish` → debug view: 2 sync cycles, then the next boundary. Release behaves symmetrically.
- `finish` pulses shorter than one frame that begin and end between boundaries are not shown.
- Reset mid-frame: abandons the scan and returns to the reset state on the next edge; there is no partial-frame output.

## Configuration
- `TUBE_LEADING_ZERO_BLANK_EN` defined: in the CPU view, digits above the most significant non-zero nibble of `sh_value` are dark, in addition to `sh_blank`.
  - Digit 0 is always shown; 0x00000000 shows a single '0'.
  - The debug view is unaffected.
- `TUBE_LEADING_ZERO_BLANK_EN` undefined: all eight nibbles are shown, subject to `sh_blank` only.

## Test plan
- Bench uses SCAN_DIV = 4.
- Reset, then idle for 1 frame → `tube_scan` walks 01,02,…,80, 4 cycles each. Right bus = 3F for idx 0–3 and left = 00; left bus = 3F for idx 4–7 and right = 00.
- Write `value` = 0x12345678 mid-frame → the current frame still shows 0. The next frame shows digits 0..7 = 7F,07,7D,6D,66,4F,5B,06.
- Write `blank` = 0xF0 with `value` = 0xDEADBEEF → digits 0..3 = 71,79,79,7C, and `tube_signal_left` = 0 for the whole frame.
- Hold `finish` = 1 with `dbg_pc` = 0x3A → from the first boundary ≥ 2 cycles later: digit 7 = 73, digit 1 = 4F, digit 0 = 77, other digits 00. Release → the CPU view returns at the following boundary.
- Write on the exact wrap cycle (idx 7→0) → the old value is shown for one more frame, then the new value. Assert `rst` at idx = 5 → outputs 00 next cycle, then the scan restarts at 0x01.
- With `TUBE_LEADING_ZERO_BLANK_EN` defined: `value` = 0x00000A05 → digits 0..2 = 6D,3F,77 and digits 3..7 dark. `value` = 0 → only digit 0 = 3F.
